// File: rtl/score_board.sv
// Pong scoreboard: BCD score counters, win detection, per-player blink
// timing and a registered seven-segment digit overlay for the pixel path.
module score_board #(
    parameter int COLOR_BITS   = 24,
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_DIGITS   = 2,
    parameter int WIN_SCORE    = 11,
    parameter int BLINK_FRAMES = 32,
    parameter int SCORE_Y      = 160,
    parameter int X_BASE       = 480,
    parameter int PLAYER_PITCH = 96
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_PLAYERS-1:0]              score_inc_i,
    input  logic                                score_clr_i,
    input  logic                                frame_i,
    input  logic [9:0]                          hpos_i,
    input  logic [9:0]                          vpos_i,
    output logic [NUM_PLAYERS*4*NUM_DIGITS-1:0] score_o,
    output logic                                game_over_o,
    output logic [NUM_PLAYERS-1:0]              winner_o,
    output logic [COLOR_BITS/3-1:0]             number_red_o,
    output logic [COLOR_BITS/3-1:0]             number_green_o,
    output logic [COLOR_BITS/3-1:0]             number_blue_o,
    output logic                                number_enable_o
);

    localparam int CW = COLOR_BITS / 3;
    localparam int SW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] BG = ~({CW{1'b1}} >> 3);

    function automatic logic [SW-1:0] to_bcd(input int v);
        logic [SW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic c;
        r = s;
        c = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (c) begin
                if (s[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = s[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Seven-segment glyph drawn into a 16x16 cell; seg = {g,f,e,d,c,b,a}.
    function automatic logic glyph(
        input logic [3:0] dig,
        input logic [3:0] x,
        input logic [3:0] y
    );
        logic [6:0] seg;
        logic hx, lft, rgt, up, lo;
        case (dig)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        hx  = (x >= 4'd3) && (x <= 4'd12);
        lft = (x == 4'd3) || (x == 4'd4);
        rgt = (x == 4'd11) || (x == 4'd12);
        up  = (y >= 4'd1) && (y <= 4'd8);
        lo  = (y >= 4'd7) && (y <= 4'd14);
        return (seg[0] && hx && (y == 4'd1 || y == 4'd2))
            || (seg[1] && rgt && up)
            || (seg[2] && rgt && lo)
            || (seg[3] && hx && (y == 4'd13 || y == 4'd14))
            || (seg[4] && lft && lo)
            || (seg[5] && lft && up)
            || (seg[6] && hx && (y == 4'd7 || y == 4'd8));
    endfunction

    logic [SW-1:0]          score_q [NUM_PLAYERS];
    logic [7:0]             blink_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] winner_q;
    logic [NUM_PLAYERS-1:0] acc;
    logic [NUM_PLAYERS-1:0] hidden;
    logic [3:0]             frame_cnt;

    assign winner_o    = winner_q;
    assign game_over_o = |winner_q;
    assign acc         = score_inc_i & {NUM_PLAYERS{~game_over_o}};

    always_comb begin
        score_o = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            score_o[p*SW +: SW] = score_q[p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            winner_q  <= '0;
            frame_cnt <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                score_q[p] <= '0;
                blink_q[p] <= '0;
            end
        end else begin
            if (frame_i) begin
                frame_cnt <= frame_cnt + 4'd1;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (score_clr_i) begin
                    score_q[p]  <= '0;
                    blink_q[p]  <= '0;
                    winner_q[p] <= 1'b0;
                end else if (acc[p]) begin
                    score_q[p]  <= bcd_inc(score_q[p]);
                    blink_q[p]  <= 8'(BLINK_FRAMES);
                    winner_q[p] <= (bcd_inc(score_q[p]) == WIN_BCD);
                end else if (frame_i && blink_q[p] != 8'd0) begin
                    blink_q[p] <= blink_q[p] - 8'd1;
                end
            end
        end
    end

    // A winner flashes from the free-running frame count until the next clear.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            hidden[p] = (blink_q[p] != 8'd0 && blink_q[p][2])
                     || (winner_q[p] && frame_cnt[3]);
        end
    end

    logic hit;
    logic ink;
    logic in_row;

    always_comb begin
        hit    = 1'b0;
        ink    = 1'b0;
        in_row = (int'(vpos_i) >= SCORE_Y) && (int'(vpos_i) < SCORE_Y + 16);
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                int x0;
                x0 = X_BASE + p * PLAYER_PITCH + 16 * d;
                if (in_row && int'(hpos_i) >= x0 && int'(hpos_i) < x0 + 16) begin
                    hit = 1'b1;
                    ink = !hidden[p] && glyph(score_q[p][4*(NUM_DIGITS-1-d) +: 4],
                                              hpos_i[3:0], vpos_i[3:0]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            number_enable_o <= 1'b0;
            number_red_o    <= '0;
            number_green_o  <= '0;
            number_blue_o   <= '0;
        end else begin
            number_enable_o <= hit;
            number_red_o    <= (hit && !ink) ? BG : '0;
            number_green_o  <= (hit && !ink) ? BG : '0;
            number_blue_o   <= (hit && !ink) ? BG : '0;
        end
    end

endmodule
